// File: rtl/xdma_axi4lite_bar_arbiter.sv
// Two-requester AXI4-Lite arbiter sharing the XDMA BAR register-file slave.
// Write and read channels each own an independent round-robin grant FSM.
//   state | meaning
//   IDLE  | no owner; arbitrate on awvalid (write) / arvalid (read), grant lands next edge
//   BUSY  | owner holds the channel; address and data forwarded once, released on the B/R handshake
module xdma_axi4lite_bar_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   io_s0_axi_write_awaddr,
  input  logic                io_s0_axi_write_awvalid,
  output logic                io_s0_axi_write_awready,
  input  logic [DATA_W-1:0]   io_s0_axi_write_wdata,
  input  logic [DATA_W/8-1:0] io_s0_axi_write_wstrb,
  input  logic                io_s0_axi_write_wvalid,
  output logic                io_s0_axi_write_wready,
  output logic [1:0]          io_s0_axi_write_bresp,
  output logic                io_s0_axi_write_bvalid,
  input  logic                io_s0_axi_write_bready,
  input  logic [ADDR_W-1:0]   io_s0_axi_read_araddr,
  input  logic                io_s0_axi_read_arvalid,
  output logic                io_s0_axi_read_arready,
  output logic [DATA_W-1:0]   io_s0_axi_read_rdata,
  output logic [1:0]          io_s0_axi_read_rresp,
  output logic                io_s0_axi_read_rvalid,
  input  logic                io_s0_axi_read_rready,
  input  logic [ADDR_W-1:0]   io_s1_axi_write_awaddr,
  input  logic                io_s1_axi_write_awvalid,
  output logic                io_s1_axi_write_awready,
  input  logic [DATA_W-1:0]   io_s1_axi_write_wdata,
  input  logic [DATA_W/8-1:0] io_s1_axi_write_wstrb,
  input  logic                io_s1_axi_write_wvalid,
  output logic                io_s1_axi_write_wready,
  output logic [1:0]          io_s1_axi_write_bresp,
  output logic                io_s1_axi_write_bvalid,
  input  logic                io_s1_axi_write_bready,
  input  logic [ADDR_W-1:0]   io_s1_axi_read_araddr,
  input  logic                io_s1_axi_read_arvalid,
  output logic                io_s1_axi_read_arready,
  output logic [DATA_W-1:0]   io_s1_axi_read_rdata,
  output logic [1:0]          io_s1_axi_read_rresp,
  output logic                io_s1_axi_read_rvalid,
  input  logic                io_s1_axi_read_rready,
  output logic [ADDR_W-1:0]   io_m_axi_write_awaddr,
  output logic                io_m_axi_write_awvalid,
  input  logic                io_m_axi_write_awready,
  output logic [DATA_W-1:0]   io_m_axi_write_wdata,
  output logic [DATA_W/8-1:0] io_m_axi_write_wstrb,
  output logic                io_m_axi_write_wvalid,
  input  logic                io_m_axi_write_wready,
  input  logic [1:0]          io_m_axi_write_bresp,
  input  logic                io_m_axi_write_bvalid,
  output logic                io_m_axi_write_bready,
  output logic [ADDR_W-1:0]   io_m_axi_read_araddr,
  output logic                io_m_axi_read_arvalid,
  input  logic                io_m_axi_read_arready,
  input  logic [DATA_W-1:0]   io_m_axi_read_rdata,
  input  logic [1:0]          io_m_axi_read_rresp,
  input  logic                io_m_axi_read_rvalid,
  output logic                io_m_axi_read_rready,
  output logic [1:0]          io_wr_owner,
  output logic [1:0]          io_rd_owner
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} ch_state_e;

  ch_state_e wr_state, wr_state_nxt, rd_state, rd_state_nxt;
  logic wr_own, wr_own_nxt, wprio, wprio_nxt, aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic rd_own, rd_own_nxt, rprio, rprio_nxt, ar_done, ar_done_nxt;

  // Owner-selected requester signals; only consumed while BUSY.
  logic [ADDR_W-1:0]   wr_awaddr, rd_araddr;
  logic [DATA_W-1:0]   wr_wdata;
  logic [DATA_W/8-1:0] wr_wstrb;
  logic                wr_awvalid, wr_wvalid, wr_bready, rd_arvalid, rd_rready;
  logic                aw_rdy, w_rdy, ar_rdy;

  assign wr_awaddr  = wr_own ? io_s1_axi_write_awaddr  : io_s0_axi_write_awaddr;
  assign wr_awvalid = wr_own ? io_s1_axi_write_awvalid : io_s0_axi_write_awvalid;
  assign wr_wdata   = wr_own ? io_s1_axi_write_wdata   : io_s0_axi_write_wdata;
  assign wr_wstrb   = wr_own ? io_s1_axi_write_wstrb   : io_s0_axi_write_wstrb;
  assign wr_wvalid  = wr_own ? io_s1_axi_write_wvalid  : io_s0_axi_write_wvalid;
  assign wr_bready  = wr_own ? io_s1_axi_write_bready  : io_s0_axi_write_bready;
  assign rd_araddr  = rd_own ? io_s1_axi_read_araddr   : io_s0_axi_read_araddr;
  assign rd_arvalid = rd_own ? io_s1_axi_read_arvalid  : io_s0_axi_read_arvalid;
  assign rd_rready  = rd_own ? io_s1_axi_read_rready   : io_s0_axi_read_rready;

  assign io_wr_owner = {wr_state == BUSY, (wr_state == BUSY) & wr_own};
  assign io_rd_owner = {rd_state == BUSY, (rd_state == BUSY) & rd_own};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_state <= IDLE;
      wr_own   <= 1'b0;
      wprio    <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      rd_state <= IDLE;
      rd_own   <= 1'b0;
      rprio    <= 1'b0;
      ar_done  <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      wr_own   <= wr_own_nxt;
      wprio    <= wprio_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      rd_state <= rd_state_nxt;
      rd_own   <= rd_own_nxt;
      rprio    <= rprio_nxt;
      ar_done  <= ar_done_nxt;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_own_nxt   = wr_own;
    wprio_nxt    = wprio;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    aw_rdy       = 1'b0;
    w_rdy        = 1'b0;
    io_m_axi_write_awaddr   = '0;
    io_m_axi_write_awvalid  = 1'b0;
    io_m_axi_write_wdata    = '0;
    io_m_axi_write_wstrb    = '0;
    io_m_axi_write_wvalid   = 1'b0;
    io_m_axi_write_bready   = 1'b0;
    io_s0_axi_write_awready = 1'b0;
    io_s0_axi_write_wready  = 1'b0;
    io_s0_axi_write_bresp   = 2'b00;
    io_s0_axi_write_bvalid  = 1'b0;
    io_s1_axi_write_awready = 1'b0;
    io_s1_axi_write_wready  = 1'b0;
    io_s1_axi_write_bresp   = 2'b00;
    io_s1_axi_write_bvalid  = 1'b0;
    case (wr_state)
      IDLE: begin
        if (io_s0_axi_write_awvalid | io_s1_axi_write_awvalid) begin
          wr_own_nxt   = (io_s0_axi_write_awvalid & io_s1_axi_write_awvalid) ? wprio
                                                                            : io_s1_axi_write_awvalid;
          wprio_nxt    = ~wr_own_nxt;
          wr_state_nxt = BUSY;
        end
      end
      BUSY: begin
        aw_rdy = io_m_axi_write_awready & ~aw_done;
        w_rdy  = io_m_axi_write_wready & ~w_done;
        io_m_axi_write_awaddr  = wr_awaddr;
        io_m_axi_write_awvalid = wr_awvalid & ~aw_done;
        io_m_axi_write_wdata   = wr_wdata;
        io_m_axi_write_wstrb   = wr_wstrb;
        io_m_axi_write_wvalid  = wr_wvalid & ~w_done;
        io_m_axi_write_bready  = wr_bready;
        if (wr_own) begin
          io_s1_axi_write_awready = aw_rdy;
          io_s1_axi_write_wready  = w_rdy;
          io_s1_axi_write_bresp   = io_m_axi_write_bresp;
          io_s1_axi_write_bvalid  = io_m_axi_write_bvalid;
        end else begin
          io_s0_axi_write_awready = aw_rdy;
          io_s0_axi_write_wready  = w_rdy;
          io_s0_axi_write_bresp   = io_m_axi_write_bresp;
          io_s0_axi_write_bvalid  = io_m_axi_write_bvalid;
        end
        if (wr_awvalid & aw_rdy) aw_done_nxt = 1'b1;
        if (wr_wvalid & w_rdy)   w_done_nxt  = 1'b1;
        if (io_m_axi_write_bvalid & wr_bready) begin
          aw_done_nxt  = 1'b0;
          w_done_nxt   = 1'b0;
          wr_state_nxt = IDLE;
        end
      end
      default: wr_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_own_nxt   = rd_own;
    rprio_nxt    = rprio;
    ar_done_nxt  = ar_done;
    ar_rdy       = 1'b0;
    io_m_axi_read_araddr   = '0;
    io_m_axi_read_arvalid  = 1'b0;
    io_m_axi_read_rready   = 1'b0;
    io_s0_axi_read_arready = 1'b0;
    io_s0_axi_read_rdata   = '0;
    io_s0_axi_read_rresp   = 2'b00;
    io_s0_axi_read_rvalid  = 1'b0;
    io_s1_axi_read_arready = 1'b0;
    io_s1_axi_read_rdata   = '0;
    io_s1_axi_read_rresp   = 2'b00;
    io_s1_axi_read_rvalid  = 1'b0;
    case (rd_state)
      IDLE: begin
        if (io_s0_axi_read_arvalid | io_s1_axi_read_arvalid) begin
          rd_own_nxt   = (io_s0_axi_read_arvalid & io_s1_axi_read_arvalid) ? rprio
                                                                          : io_s1_axi_read_arvalid;
          rprio_nxt    = ~rd_own_nxt;
          rd_state_nxt = BUSY;
        end
      end
      BUSY: begin
        ar_rdy = io_m_axi_read_arready & ~ar_done;
        io_m_axi_read_araddr  = rd_araddr;
        io_m_axi_read_arvalid = rd_arvalid & ~ar_done;
        io_m_axi_read_rready  = rd_rready;
        if (rd_own) begin
          io_s1_axi_read_arready = ar_rdy;
          io_s1_axi_read_rdata   = io_m_axi_read_rdata;
          io_s1_axi_read_rresp   = io_m_axi_read_rresp;
          io_s1_axi_read_rvalid  = io_m_axi_read_rvalid;
        end else begin
          io_s0_axi_read_arready = ar_rdy;
          io_s0_axi_read_rdata   = io_m_axi_read_rdata;
          io_s0_axi_read_rresp   = io_m_axi_read_rresp;
          io_s0_axi_read_rvalid  = io_m_axi_read_rvalid;
        end
        if (rd_arvalid & ar_rdy) ar_done_nxt = 1'b1;
        if (io_m_axi_read_rvalid & rd_rready) begin
          ar_done_nxt  = 1'b0;
          rd_state_nxt = IDLE;
        end
      end
      default: rd_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_xdma_axi4lite_bar_arbiter.sv
// Directed bench for the BAR arbiter: a small BAR slave model plus two requester drivers.
module tb_xdma_axi4lite_bar_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
  logic [3:0]  s_wstrb[2];
  logic [1:0]  s_bresp[2], s_rresp[2];
  logic s_awvalid[2], s_awready[2], s_wvalid[2], s_wready[2], s_bvalid[2], s_bready[2];
  logic s_arvalid[2], s_arready[2], s_rvalid[2], s_rready[2];

  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp, wr_owner, rd_owner;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic m_arvalid, m_arready, m_rvalid, m_rready;

  xdma_axi4lite_bar_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .io_s0_axi_write_awaddr(s_awaddr[0]), .io_s0_axi_write_awvalid(s_awvalid[0]),
    .io_s0_axi_write_awready(s_awready[0]), .io_s0_axi_write_wdata(s_wdata[0]),
    .io_s0_axi_write_wstrb(s_wstrb[0]), .io_s0_axi_write_wvalid(s_wvalid[0]),
    .io_s0_axi_write_wready(s_wready[0]), .io_s0_axi_write_bresp(s_bresp[0]),
    .io_s0_axi_write_bvalid(s_bvalid[0]), .io_s0_axi_write_bready(s_bready[0]),
    .io_s0_axi_read_araddr(s_araddr[0]), .io_s0_axi_read_arvalid(s_arvalid[0]),
    .io_s0_axi_read_arready(s_arready[0]), .io_s0_axi_read_rdata(s_rdata[0]),
    .io_s0_axi_read_rresp(s_rresp[0]), .io_s0_axi_read_rvalid(s_rvalid[0]),
    .io_s0_axi_read_rready(s_rready[0]),
    .io_s1_axi_write_awaddr(s_awaddr[1]), .io_s1_axi_write_awvalid(s_awvalid[1]),
    .io_s1_axi_write_awready(s_awready[1]), .io_s1_axi_write_wdata(s_wdata[1]),
    .io_s1_axi_write_wstrb(s_wstrb[1]), .io_s1_axi_write_wvalid(s_wvalid[1]),
    .io_s1_axi_write_wready(s_wready[1]), .io_s1_axi_write_bresp(s_bresp[1]),
    .io_s1_axi_write_bvalid(s_bvalid[1]), .io_s1_axi_write_bready(s_bready[1]),
    .io_s1_axi_read_araddr(s_araddr[1]), .io_s1_axi_read_arvalid(s_arvalid[1]),
    .io_s1_axi_read_arready(s_arready[1]), .io_s1_axi_read_rdata(s_rdata[1]),
    .io_s1_axi_read_rresp(s_rresp[1]), .io_s1_axi_read_rvalid(s_rvalid[1]),
    .io_s1_axi_read_rready(s_rready[1]),
    .io_m_axi_write_awaddr(m_awaddr), .io_m_axi_write_awvalid(m_awvalid),
    .io_m_axi_write_awready(m_awready), .io_m_axi_write_wdata(m_wdata),
    .io_m_axi_write_wstrb(m_wstrb), .io_m_axi_write_wvalid(m_wvalid),
    .io_m_axi_write_wready(m_wready), .io_m_axi_write_bresp(m_bresp),
    .io_m_axi_write_bvalid(m_bvalid), .io_m_axi_write_bready(m_bready),
    .io_m_axi_read_araddr(m_araddr), .io_m_axi_read_arvalid(m_arvalid),
    .io_m_axi_read_arready(m_arready), .io_m_axi_read_rdata(m_rdata),
    .io_m_axi_read_rresp(m_rresp), .io_m_axi_read_rvalid(m_rvalid),
    .io_m_axi_read_rready(m_rready),
    .io_wr_owner(wr_owner), .io_rd_owner(rd_owner)
  );

  // BAR slave model: B one cycle after both AW and W, R on the AR handshake edge.
  logic bar_aw_rdy, bar_b_hold, bar_force_b;
  logic got_aw, got_w, bar_bvalid, bar_rvalid;
  logic [1:0] bar_bresp, bar_rresp;
  logic [31:0] bar_awaddr, bar_wdata, bar_rdata;
  logic [3:0] bar_wstrb;
  int aw_beats = 0, w_beats = 0;

  assign m_awready = bar_aw_rdy;
  assign m_wready  = 1'b1;
  assign m_bvalid  = bar_bvalid | bar_force_b;
  assign m_bresp   = bar_bresp;
  assign m_arready = !bar_rvalid;
  assign m_rvalid  = bar_rvalid;
  assign m_rdata   = bar_rdata;
  assign m_rresp   = bar_rresp;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      got_aw <= 0; got_w <= 0; bar_bvalid <= 0; bar_rvalid <= 0;
      bar_bresp <= 0; bar_rresp <= 0; bar_rdata <= 0;
    end else begin
      if (m_awvalid && m_awready) begin got_aw <= 1; bar_awaddr <= m_awaddr; aw_beats <= aw_beats + 1; end
      if (m_wvalid && m_wready) begin got_w <= 1; bar_wdata <= m_wdata; bar_wstrb <= m_wstrb; w_beats <= w_beats + 1; end
      if (bar_bvalid && m_bready) begin
        bar_bvalid <= 0; got_aw <= 0; got_w <= 0;
      end else if (got_aw && got_w && !bar_bvalid && !bar_b_hold) begin
        bar_bvalid <= 1; bar_bresp <= bar_awaddr[4] ? 2'b10 : 2'b00;
      end
      if (bar_rvalid && m_rready) bar_rvalid <= 0;
      else if (m_arvalid && !bar_rvalid) begin
        bar_rvalid <= 1; bar_rdata <= 32'hC0DE_0000 | m_araddr; bar_rresp <= m_araddr[4] ? 2'b10 : 2'b00;
      end
    end
  end

  // Grant history and overlap/leak counters.
  int wr_q[$], rd_q[$];
  logic prev_wr_busy = 0, prev_rd_busy = 0;
  int cnt_s0_rvalid = 0, cnt_overlap = 0;
  always @(negedge clock) begin
    if (wr_owner[1] && !prev_wr_busy) wr_q.push_back(int'(wr_owner[0]));
    if (rd_owner[1] && !prev_rd_busy) rd_q.push_back(int'(rd_owner[0]));
    prev_wr_busy = wr_owner[1];
    prev_rd_busy = rd_owner[1];
    if (s_rvalid[0]) cnt_s0_rvalid++;
    if (wr_owner == 2'b10 && rd_owner == 2'b11) cnt_overlap++;
  end

  int total = 0, bad = 0;
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] vr_vec();
    return {s_awready[0], s_awready[1], s_wready[0], s_wready[1], s_bvalid[0], s_bvalid[1],
            s_arready[0], s_arready[1], s_rvalid[0], s_rvalid[1],
            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, wr_owner, rd_owner};
  endfunction

  task automatic clear_drv();
    for (int i = 0; i < 2; i++) begin
      s_awaddr[i] = 0; s_wdata[i] = 0; s_wstrb[i] = 0; s_araddr[i] = 0;
      s_awvalid[i] = 0; s_wvalid[i] = 0; s_bready[i] = 0; s_arvalid[i] = 0; s_rready[i] = 0;
    end
    bar_aw_rdy = 1; bar_b_hold = 0; bar_force_b = 0;
  endtask

  task automatic apply_reset();
    clear_drv();
    reset = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
  endtask

  task automatic do_write(input int n, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    bit aw_p = 1, w_p = 1, hs_aw, hs_w;
    int cyc = 0;
    s_awaddr[n] = addr; s_wdata[n] = data; s_wstrb[n] = strb;
    s_awvalid[n] = 1; s_wvalid[n] = 1; s_bready[n] = 0;
    while ((aw_p || w_p) && cyc < 200) begin
      @(negedge clock);
      hs_aw = aw_p && s_awready[n];
      hs_w  = w_p && s_wready[n];
      @(posedge clock); #1;
      if (hs_aw) begin aw_p = 0; s_awvalid[n] = 0; end
      if (hs_w)  begin w_p = 0; s_wvalid[n] = 0; end
      cyc++;
    end
    s_bready[n] = 1;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clock);
      if (s_bvalid[n]) break;
      cyc++;
    end
    resp = s_bresp[n];
    check_val("wr_timeout", {aw_p, w_p, cyc >= 200}, 0);
    @(posedge clock); #1;
    s_bready[n] = 0;
  endtask

  task automatic do_read(input int n, input logic [31:0] addr, output logic [31:0] data);
    bit hs = 0;
    int cyc = 0, cyc2 = 0;
    s_araddr[n] = addr; s_arvalid[n] = 1; s_rready[n] = 0;
    while (!hs && cyc < 200) begin
      @(negedge clock);
      hs = s_arready[n];
      @(posedge clock); #1;
      if (hs) s_arvalid[n] = 0;
      cyc++;
    end
    s_rready[n] = 1;
    while (cyc2 < 200) begin
      @(negedge clock);
      if (s_rvalid[n]) break;
      cyc2++;
    end
    data = s_rdata[n];
    check_val("rd_timeout", {!hs, cyc2 >= 200}, 0);
    @(posedge clock); #1;
    s_rready[n] = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r0, r1;
    logic [31:0] rd;
    int base, wb0, ab0, rv0, ov0;

    clear_drv();
    #1 check_val("rst_outputs", vr_vec(), 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    check_val("post_rst_idle", vr_vec(), 0);

    // single s0 write, BAR ready immediately
    s_awaddr[0] = 32'h4; s_wdata[0] = 32'hA5A5_0001; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1; s_wvalid[0] = 1; s_bready[0] = 1;
    @(negedge clock) check_val("t1_arb_latency", {m_awvalid, m_wvalid, s_awready[0], wr_owner}, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_val("t1_forward", {m_awvalid, m_wvalid, s_awready[0], s_wready[0]}, 4'hF);
    check_val("t1_owner", wr_owner, 2'b10);
    check_val("t1_awaddr", m_awaddr, 32'h4);
    check_val("t1_wdata", m_wdata, 32'hA5A5_0001);
    @(posedge clock); #1;
    s_awvalid[0] = 0; s_wvalid[0] = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check_val("t1_bresp", {s_bvalid[0], s_bresp[0], s_bvalid[1]}, 4'b1000);
    check_val("t1_bar_data", {bar_wdata, bar_wstrb}, {32'hA5A5_0001, 4'hF});
    @(posedge clock); #1;
    s_bready[0] = 0;
    @(negedge clock) check_val("t1_release", wr_owner, 0);
    @(posedge clock); #1;

    // simultaneous pairs and pointer alternation
    apply_reset();
    base = wr_q.size();
    fork
      do_write(0, 32'h20, 32'h1111_0000, 4'hF, r0);
      do_write(1, 32'h24, 32'h2222_0000, 4'h3, r1);
    join
    check_val("t2_pair1_first", wr_q[base], 0);
    check_val("t2_pair1_second", wr_q[base+1], 1);
    check_val("t2_pair1_last_data", bar_wdata, 32'h2222_0000);
    do_write(0, 32'h28, 32'h3333_0000, 4'hF, r0);
    base = wr_q.size();
    fork
      do_write(0, 32'h20, 32'h4444_0000, 4'hF, r0);
      do_write(1, 32'h24, 32'h5555_0000, 4'h1, r1);
    join
    check_val("t2_pair2_first", wr_q[base], 1);
    check_val("t2_pair2_second", wr_q[base+1], 0);
    check_val("t2_pair2_last_data", bar_wdata, 32'h4444_0000);

    // s0 streams three writes against one pending s1 write
    apply_reset();
    base = wr_q.size();
    fork
      begin repeat (3) do_write(0, 32'h40, 32'h6666_0000, 4'hF, r0); end
      do_write(1, 32'h44, 32'h7777_0000, 4'hF, r1);
    join
    check_val("t3_order", {wr_q[base][1:0], wr_q[base+1][1:0], wr_q[base+2][1:0], wr_q[base+3][1:0]},
              {2'd0, 2'd1, 2'd0, 2'd0});

    // s1 read concurrent with s0 write
    base = rd_q.size();
    rv0 = cnt_s0_rvalid; ov0 = cnt_overlap;
    fork
      do_read(1, 32'h8, rd);
      do_write(0, 32'h0, 32'h5A5A_0000, 4'hF, r0);
    join
    check_val("t4_rdata", rd, 32'hC0DE_0008);
    check_val("t4_rd_owner", rd_q[base], 1);
    check_val("t4_s0_rvalid", cnt_s0_rvalid - rv0, 0);
    check_val("t4_overlap", cnt_overlap > ov0, 1);
    check_val("t4_write", {r0, bar_awaddr, bar_wdata}, {2'b00, 32'h0, 32'h5A5A_0000});

    // s1 presents W two cycles ahead of AW; BAR stalls AW
    bar_aw_rdy = 0; wb0 = w_beats; ab0 = aw_beats;
    s_wdata[1] = 32'hBEEF_0005; s_wstrb[1] = 4'hC; s_awaddr[1] = 32'h10;
    s_wvalid[1] = 1; s_bready[1] = 1;
    @(negedge clock) check_val("t5_w_only_idle", {m_wvalid, s_wready[1], wr_owner}, 0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    s_awvalid[1] = 1;
    @(posedge clock); #1;
    @(negedge clock);
    check_val("t5_w_first", {m_wvalid, m_awvalid, s_wready[1], s_awready[1]}, 4'b1110);
    check_val("t5_owner", wr_owner, 2'b11);
    @(posedge clock); #1;
    @(negedge clock);
    check_val("t5_w_done", {m_wvalid, s_wready[1]}, 0);
    check_val("t5_beats_mid", {w_beats - wb0, aw_beats - ab0}, {32'd1, 32'd0});
    @(posedge clock); #1;
    bar_aw_rdy = 1; s_wvalid[1] = 0;
    @(negedge clock) check_val("t5_aw_fwd", {m_awvalid, s_awready[1]}, 2'b11);
    @(posedge clock); #1;
    s_awvalid[1] = 0;
    @(posedge clock); #1;
    @(negedge clock);
    check_val("t5_b_route", {s_bvalid[1], s_bvalid[0], s_bresp[1]}, 4'b1010);
    check_val("t5_bar_data", {bar_awaddr, bar_wdata, bar_wstrb}, {32'h10, 32'hBEEF_0005, 4'hC});
    @(posedge clock); #1;
    s_bready[1] = 0;
    @(negedge clock);
    check_val("t5_release", wr_owner, 0);
    check_val("t5_one_w_beat", w_beats - wb0, 1);
    @(posedge clock); #1;

    // reset while a write awaits B
    bar_b_hold = 1;
    s_awaddr[0] = 32'h30; s_wdata[0] = 32'h0BAD_0030; s_wstrb[0] = 4'hF;
    s_awvalid[0] = 1; s_wvalid[0] = 1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    s_awvalid[0] = 0; s_wvalid[0] = 0; s_bready[0] = 1;
    @(posedge clock); #1;
    bar_force_b = 1;
    @(negedge clock) check_val("t6_pre_reset", {wr_owner, s_bvalid[0], m_bready}, 4'b1011);
    #2 reset = 0;
    #1 check_val("t6_reset_outputs", vr_vec(), 0);
    s_bready[1] = 1;
    @(posedge clock); #1;
    @(negedge clock) reset = 1;
    @(posedge clock); #1;
    @(negedge clock) check_val("t6_idle_b_ignored", {s_bvalid[0], s_bvalid[1], m_bready, wr_owner}, 0);
    @(posedge clock); #1;
    bar_force_b = 0; bar_b_hold = 0; s_bready[0] = 0; s_bready[1] = 0;
    @(posedge clock); #1;
    base = wr_q.size();
    do_write(1, 32'h34, 32'h1234_5678, 4'hF, r1);
    check_val("t6_s1_granted", wr_q[base], 1);
    check_val("t6_s1_write", {r1, bar_awaddr, bar_wdata}, {2'b00, 32'h34, 32'h1234_5678});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xdma_axi4lite_bar_arbiter.md
Name: xdma_axi4lite_bar_arbiter

Overview:
- Two-requester AXI4-Lite arbiter in front of the single XDMA BAR register-file slave.
- Lets the host XDMA path (port s0) and an on-chip debug/config master (port s1) share the BAR.
- Write and read channels are arbitrated independently.
- Each granted transaction is held until its response handshake completes.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; wstrb width is DATA_W/8

Ports:
clock  input  1  single clock
reset  input  1  asynchronous, active-low reset
io_sN_axi_write_awaddr  input  ADDR_W  requester N write address (N=0,1)
io_sN_axi_write_awvalid  input  1  requester N AW valid
io_sN_axi_write_awready  output  1  requester N AW ready
io_sN_axi_write_wdata  input  DATA_W  requester N write data
io_sN_axi_write_wstrb  input  DATA_W/8  requester N byte strobes
io_sN_axi_write_wvalid  input  1  requester N W valid
io_sN_axi_write_wready  output  1  requester N W ready
io_sN_axi_write_bresp  output  2  requester N B response
io_sN_axi_write_bvalid  output  1  requester N B valid
io_sN_axi_write_bready  input  1  requester N B ready
io_sN_axi_read_araddr  input  ADDR_W  requester N read address
io_sN_axi_read_arvalid  input  1  requester N AR valid
io_sN_axi_read_arready  output  1  requester N AR ready
io_sN_axi_read_rdata  output  DATA_W  requester N read data
io_sN_axi_read_rresp  output  2  requester N R response
io_sN_axi_read_rvalid  output  1  requester N R valid
io_sN_axi_read_rready  input  1  requester N R ready
io_m_axi_write_*  mirror of one sN write group, opposite directions (to BAR)
io_m_axi_read_*  mirror of one sN read group, opposite directions (to BAR)
io_wr_owner  output  2  {busy, owner index} of write channel
io_rd_owner  output  2  {busy, owner index} of read channel

Behaviour:
- Reset: asserting reset low immediately forces both channel FSMs to IDLE, both priority pointers to 0, and aw_done/w_done to 0. Reset value is 0 for every valid/ready output on every port and for io_wr_owner/io_rd_owner. Data/resp outputs may carry don't-care but must be deterministic; drive 0 when not granted.
- Write FSM states:
  - IDLE: request qualifier is awvalid only. If exactly one sN has awvalid, grant it. If both do, grant wprio. Grant is registered: the FSM enters BUSY(owner) on the next edge, and wprio <= ~owner. No ready is driven in IDLE (1-cycle arbitration latency).
  - BUSY(o):
    - io_m_awvalid = so_awvalid & ~aw_done; so_awready = io_m_awready & ~aw_done; the m handshake sets aw_done.
    - io_m_wvalid = so_wvalid & ~w_done; so_wready = io_m_wready & ~w_done; the m handshake sets w_done.
    - W may complete before, with, or after AW.
    - io_m_bready = so_bready; so_bvalid/bresp = io_m_bvalid/bresp.
    - On the B handshake: clear aw_done/w_done and go to IDLE. IDLE lasts at least 1 cycle, so there is no back-to-back grant in the same cycle.
  - The non-owner always sees ready=0 and bvalid=0.
- Read FSM: same structure. Qualifier is arvalid; pointer is rprio. AR is forwarded once (ar_done). R is forwarded to the owner only. Release on the R handshake.
- Write and read FSMs are fully independent: s0 may own write while s1 owns read, or one requester may own both.
- Fairness: after each grant, the pointer points to the other requester. A requester continuously asserting valid can win at most one consecutive grant while the other is waiting.
- Requester valid dropping while granted is a protocol violation. Required response: no deadlock beyond the BAR response; the FSM still waits for B/R.
- An io_m bvalid/rvalid arriving while the channel is IDLE is ignored, with bready/rready held 0.
- The arbiter adds no combinational path from sN inputs to sN outputs other than through io_m. Owner select and done flags are registers only.

Test Plan:
- s0 writes 0xA5A5_0001, strb 0xF, to 0x4; BAR ready immediately -> io_m AW/W seen in cycle 2 after awvalid, s0 bvalid with bresp=0; io_wr_owner = 2'b10 during the transaction, 0 after.
- s0 and s1 both assert awvalid in the same cycle after reset -> s0 is served first, then s1. A subsequent simultaneous pair is served s1 first (pointer alternation).
- s0 holds awvalid continuously for 3 writes while s1 has 1 pending -> order s0, s1, s0, s0.
- s1 reads 0x8 while s0 writes 0x0 concurrently -> both complete with overlapping channel ownership; rdata goes only to s1; s0 rvalid stays 0 throughout.
- s1 presents W 2 cycles before AW -> io_m wvalid is forwarded first, w_done is set, and there is exactly one W beat on io_m; B returns to s1 only.
- Reset asserted low while a write is awaiting B -> all ready/valid outputs are 0 immediately. After release, a new s1 request is granted (pointer=0, with s0 idle).
